// File: rtl/portal_msg_assembler.sv
// Frames the bridge word stream into portal request messages:
// one header word (method, len) followed by len payload words.
module portal_msg_assembler #(
    parameter int MAX_WORDS = 4,
    parameter int ERR_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_enq__ENA,
    input  logic [31:0]            in_enq_v,
    output logic                   in_enq__RDY,
    output logic                   out_enq__ENA,
    output logic [15:0]            out_enq_method,
    output logic [15:0]            out_enq_len,
    output logic [MAX_WORDS*32-1:0] out_enq_data,
    input  logic                   out_enq__RDY,
    output logic [ERR_WIDTH-1:0]   errCount
);

    typedef enum logic [1:0] {HDR, PAY, DRAIN, SEND} state_t;

    localparam logic [15:0] MAXW = 16'(MAX_WORDS);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    state_t                      state;
    logic                        rdy_q;
    logic [15:0]                 method_q;
    logic [15:0]                 len_q;
    logic [15:0]                 idx;
    logic [15:0]                 remaining;
    logic [MAX_WORDS-1:0][31:0]  data_q;
    logic [ERR_WIDTH-1:0]        err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= HDR;
            rdy_q     <= 1'b1;
            method_q  <= '0;
            len_q     <= '0;
            idx       <= '0;
            remaining <= '0;
            data_q    <= '0;
            err_q     <= '0;
        end else begin
            unique case (state)
                HDR: begin
                    if (in_enq__ENA) begin
                        method_q  <= in_enq_v[31:16];
                        len_q     <= in_enq_v[15:0];
                        remaining <= in_enq_v[15:0];
                        data_q    <= '0;
                        idx       <= '0;
                        if (in_enq_v[15:0] == 16'd0) begin
                            state <= SEND;
                            rdy_q <= 1'b0;
                        end else if (in_enq_v[15:0] <= MAXW) begin
                            state <= PAY;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                PAY: begin
                    if (in_enq__ENA) begin
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            if (idx == 16'(i)) data_q[i] <= in_enq_v;
                        end
                        idx <= idx + 16'd1;
                        if (idx == len_q - 16'd1) begin
                            state <= SEND;
                            rdy_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (in_enq__ENA) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= HDR;
                            if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_enq__RDY) begin
                        state <= HDR;
                        rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= HDR;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_enq__RDY    = rdy_q;
    assign out_enq__ENA   = (state == SEND) && out_enq__RDY;
    assign out_enq_method = method_q;
    assign out_enq_len    = len_q;
    assign out_enq_data   = data_q;
    assign errCount       = err_q;

endmodule
